// File: rtl/led_display_scanner.sv
// Multiplexed 7-segment display scanner with shadow registers, PWM dimming and anti-ghost blanking.
// Optional blink support is compiled in with `define LED_DISPLAY_BLINK_EN.
module led_display_scanner #(
    parameter int NUM_DIGITS     = 6,
    parameter int CLK_RATE_HZ    = 100000000,
    parameter int DIGIT_RATE_HZ  = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1,
    parameter int BRIGHT_BITS    = 3,
    parameter int BLINK_HZ       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   digit_enable_mask,
    input  logic [NUM_DIGITS-1:0]   decimal_point_enable_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    input  logic                    update,
    output logic                    update_ack,
    output logic [7:0]              display_led_segments,
    output logic [NUM_DIGITS-1:0]   display_led_enable_mask,
    output logic                    frame_start
);

    localparam int DWELL   = CLK_RATE_HZ / DIGIT_RATE_HZ;
    localparam int PRESC_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DWELL - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] EN_OFF  = (EN_ACTIVE_LOW != 0) ? '1 : '0;

    generate
        if (DWELL < 4) begin : g_bad_dwell
            $error("led_display_scanner: DWELL must be at least 4 cycles");
        end
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("led_display_scanner: NUM_DIGITS must be 1..8");
        end
    endgenerate

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BRIGHT_BITS-1:0]  pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
    logic [NUM_DIGITS-1:0]   den_sh_q, den_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [BRIGHT_BITS-1:0]  bright_sh_q, bright_sh_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    ack_q, ack_d;
    logic                    frame_q, frame_d;
    logic                    capture;
    logic                    blink_off;
    logic [3:0]              nibble;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   en_act;
    logic                    lit;

`ifdef LED_DISPLAY_BLINK_EN
    localparam int BLINK_HALF = CLK_RATE_HZ / (2 * BLINK_HZ);
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0] blink_sh_q, blink_sh_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        blink_sh_d    = capture ? blink_mask : blink_sh_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        blink_off = blink_phase_q & blink_sh_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blink_sh_q    <= '0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            blink_sh_q    <= blink_sh_d;
        end
    end
`else
    localparam int unused_blink_hz = BLINK_HZ;
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign blink_off = 1'b0;
`endif

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        pwm_d   = pwm_q + 1'b1;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // New contents only land at the very end of a frame so a frame is never torn.
        capture     = (presc_q == PRESC_LAST) && (idx_q == IDX_LAST) && update;
        data_sh_d   = capture ? data : data_sh_q;
        den_sh_d    = capture ? digit_enable_mask : den_sh_q;
        dp_sh_d     = capture ? decimal_point_enable_mask : dp_sh_q;
        bright_sh_d = capture ? brightness : bright_sh_q;
        ack_d       = capture;
        frame_d     = (presc_q == '0) && (idx_q == '0);

        nibble = data_sh_q[4*int'(idx_q) +: 4];
        case (nibble)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase

        // The first cycle of every dwell is blanked to hide ghosting while segments settle.
        lit = (presc_q != '0) && (pwm_q <= bright_sh_q) && den_sh_q[idx_q] && !blink_off;
        en_act         = '0;
        en_act[idx_q]  = lit;
        seg_d = {dp_sh_q[idx_q], glyph} ^ SEG_OFF;
        en_d  = en_act ^ EN_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pwm_q       <= '0;
            data_sh_q   <= '0;
            den_sh_q    <= '0;
            dp_sh_q     <= '0;
            bright_sh_q <= '0;
            seg_q       <= SEG_OFF;
            en_q        <= EN_OFF;
            ack_q       <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pwm_q       <= pwm_d;
            data_sh_q   <= data_sh_d;
            den_sh_q    <= den_sh_d;
            dp_sh_q     <= dp_sh_d;
            bright_sh_q <= bright_sh_d;
            seg_q       <= seg_d;
            en_q        <= en_d;
            ack_q       <= ack_d;
            frame_q     <= frame_d;
        end
    end

    assign update_ack              = ack_q;
    assign display_led_segments    = seg_q;
    assign display_led_enable_mask = en_q;
    assign frame_start             = frame_q;

endmodule

// File: tb/tb_led_display_scanner.sv
// Directed bench for led_display_scanner: 4 digits, DWELL=4, 2-bit brightness, active-high outputs.
module tb_led_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic [3:0]  digit_enable_mask;
    logic [3:0]  decimal_point_enable_mask;
    logic [3:0]  blink_mask;
    logic [1:0]  brightness;
    logic        update;
    logic        update_ack;
    logic [7:0]  display_led_segments;
    logic [3:0]  display_led_enable_mask;
    logic        frame_start;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  en_mask;
        logic [3:0]  dp;
        logic [1:0]  bright;
        logic [31:0] segs;     // expected segments {digit3,digit2,digit1,digit0}
        logic [3:0]  on_mask;  // prescaler phases where an enabled digit is lit
    } vec_t;

    vec_t vecs[4];

    led_display_scanner #(
        .NUM_DIGITS(4), .CLK_RATE_HZ(10000), .DIGIT_RATE_HZ(2500),
        .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0), .BRIGHT_BITS(2), .BLINK_HZ(1000)
    ) dut (
        .clk(clk), .reset(reset), .data(data),
        .digit_enable_mask(digit_enable_mask),
        .decimal_point_enable_mask(decimal_point_enable_mask),
        .blink_mask(blink_mask), .brightness(brightness), .update(update),
        .update_ack(update_ack), .display_led_segments(display_led_segments),
        .display_led_enable_mask(display_led_enable_mask), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_inputs(input int vi);
        data                      = vecs[vi].data;
        digit_enable_mask         = vecs[vi].en_mask;
        decimal_point_enable_mask = vecs[vi].dp;
        brightness                = vecs[vi].bright;
        blink_mask                = 4'b0000;
    endtask

    // Starts on a frame boundary; ack expected only on the 16th tick (the capture).
    task automatic load(input int vi, input logic keep);
        set_inputs(vi);
        update = 1'b1;
        for (int o = 0; o < 16; o++) begin
            tick();
            check("load_ack", 32'(update_ack), (o == 15) ? 32'd1 : 32'd0);
        end
        if (!keep) update = 1'b0;
    endtask

    task automatic check_frame(input int vi, input logic last_ack);
        for (int o = 0; o < 16; o++) begin
            int d;
            int p;
            logic [3:0] exp_en;
            tick();
            d = o / 4;
            p = o % 4;
            exp_en = (vecs[vi].en_mask[d] && vecs[vi].on_mask[p]) ? 4'(1 << d) : 4'b0000;
            check("frame_seg", 32'(display_led_segments), 32'(vecs[vi].segs[d*8 +: 8]));
            check("frame_en", 32'(display_led_enable_mask), 32'(exp_en));
            check("frame_start", 32'(frame_start), (o == 0) ? 32'd1 : 32'd0);
            check("frame_ack", 32'(update_ack), (o == 15) ? 32'(last_ack) : 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{data: 16'h8A21, en_mask: 4'b1111, dp: 4'b0101, bright: 2'd3,
                    segs: 32'h7F_F7_5B_86, on_mask: 4'b1110};
        vecs[1] = '{data: 16'h8A21, en_mask: 4'b1111, dp: 4'b0101, bright: 2'd0,
                    segs: 32'h7F_F7_5B_86, on_mask: 4'b0000};
        vecs[2] = '{data: 16'hF0A2, en_mask: 4'b1010, dp: 4'b1000, bright: 2'd2,
                    segs: 32'hF1_3F_77_5B, on_mask: 4'b0110};
        vecs[3] = '{data: 16'h0000, en_mask: 4'b0000, dp: 4'b0000, bright: 2'd0,
                    segs: 32'h3F_3F_3F_3F, on_mask: 4'b0000};

        reset = 1'b1;
        update = 1'b0;
        set_inputs(3);
        repeat (3) tick();
        check("rst_seg", 32'(display_led_segments), 32'd0);
        check("rst_en", 32'(display_led_enable_mask), 32'd0);
        check("rst_ack", 32'(update_ack), 32'd0);
        check("rst_frame", 32'(frame_start), 32'd0);
        reset = 1'b0;

        // Idle after reset: blank shadows, frame_start every 16 cycles.
        for (int f = 0; f < 3; f++) check_frame(3, 1'b0);

        // Table: load each vector at a frame end, then check the following frame.
        for (int vi = 0; vi < 3; vi++) begin
            load(vi, 1'b0);
            check_frame(vi, 1'b0);
        end

        // Short mid-frame update pulse is dropped; vector 2 stays on display.
        for (int i = 0; i < 4; i++) begin tick(); check("mid_ack", 32'(update_ack), 32'd0); end
        data = 16'h1111;
        digit_enable_mask = 4'b0001;
        update = 1'b1;
        for (int i = 0; i < 2; i++) begin tick(); check("mid_ack", 32'(update_ack), 32'd0); end
        update = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); check("mid_ack", 32'(update_ack), 32'd0); end
        check_frame(2, 1'b0);

        // Update held past the ack recaptures at the next frame end.
        load(0, 1'b1);
        set_inputs(1);
        check_frame(0, 1'b1);
        update = 1'b0;
        check_frame(1, 1'b0);

        // Reset coincident with the capture cycle wins.
        set_inputs(0);
        update = 1'b1;
        for (int i = 0; i < 15; i++) begin tick(); check("pre_rst_ack", 32'(update_ack), 32'd0); end
        reset = 1'b1;
        tick();
        check("caprst_ack", 32'(update_ack), 32'd0);
        check("caprst_seg", 32'(display_led_segments), 32'd0);
        check("caprst_en", 32'(display_led_enable_mask), 32'd0);
        check("caprst_frame", 32'(frame_start), 32'd0);
        reset = 1'b0;
        update = 1'b0;
        check_frame(3, 1'b0);

`ifdef LED_DISPLAY_BLINK_EN
        // Digit 1 blinks with 5-cycle phases; blink counter restarted at the last reset.
        set_inputs(0);
        blink_mask = 4'b0010;
        update = 1'b1;
        for (int o = 0; o < 16; o++) begin
            tick();
            check("blink_load_ack", 32'(update_ack), (o == 15) ? 32'd1 : 32'd0);
        end
        update = 1'b0;
        for (int j = 0; j < 32; j++) begin
            int s;
            int d;
            int p;
            logic [3:0] exp_en;
            tick();
            s = 32 + j;
            d = (s / 4) % 4;
            p = s % 4;
            exp_en = (p != 0 && !(d == 1 && ((s / 5) % 2) == 1)) ? 4'(1 << d) : 4'b0000;
            check("blink_en", 32'(display_led_enable_mask), 32'(exp_en));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_display_scanner.md
LED_DISPLAY_SCANNER -- requirements
Module: led_display_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of multiplexed digits (legal range 1..8).
REQ-002 SHALL have parameter CLK_RATE_HZ, default 100000000, clk frequency.
REQ-003 SHALL have parameter DIGIT_RATE_HZ, default 1000, digit-advance rate; DWELL = CLK_RATE_HZ/DIGIT_RATE_HZ cycles, elaboration error if DWELL < 4.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1; when 1, segment outputs are inverted.
REQ-005 SHALL have parameter EN_ACTIVE_LOW, default 1; when 1, digit enable outputs are inverted.
REQ-006 SHALL have parameter BRIGHT_BITS, default 3, brightness width.
REQ-007 SHALL have parameter BLINK_HZ, default 2, blink toggle rate; BLINK_HALF = CLK_RATE_HZ/(2*BLINK_HZ) cycles.
REQ-008 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1, synchronous, active-high.
REQ-010 SHALL have port data, input, 4*NUM_DIGITS, hex nibble per digit; digit 0 = bits [3:0].
REQ-011 SHALL have port digit_enable_mask, input, NUM_DIGITS, 1 = digit shown.
REQ-012 SHALL have port decimal_point_enable_mask, input, NUM_DIGITS, 1 = dp lit.
REQ-013 SHALL have port blink_mask, input, NUM_DIGITS, 1 = digit blinks.
REQ-014 SHALL have port brightness, input, BRIGHT_BITS, PWM duty level.
REQ-015 SHALL have port update, input, 1, level request to load new display contents.
REQ-016 SHALL have port update_ack, output, 1, one-cycle pulse confirming a load.
REQ-017 SHALL have port display_led_segments, output, 8, {dp,g,f,e,d,c,b,a}.
REQ-018 SHALL have port display_led_enable_mask, output, NUM_DIGITS, one-hot digit select.
REQ-019 SHALL have port frame_start, output, 1, one-cycle pulse when digit 0 dwell begins.

Function
REQ-020 SHALL keep shadow registers for data, digit_enable_mask, decimal_point_enable_mask, blink_mask, brightness; display uses shadows only.
REQ-021 SHALL count prescaler 0..DWELL-1; at DWELL-1 digit index advances, wrapping NUM_DIGITS-1 -> 0.
REQ-022 SHALL capture all inputs into shadows in the cycle where prescaler = DWELL-1, index = NUM_DIGITS-1 and update = 1; update_ack SHALL pulse exactly one cycle, the next cycle.
REQ-023 SHALL drop a request silently if update deasserts before the capture cycle; update held after ack SHALL cause a fresh capture at the next frame end.
REQ-024 SHALL register all outputs; segments/enable reflect index and prescaler with one cycle latency.
REQ-025 SHALL drive all enables inactive while prescaler = 0 (anti-ghost blanking cycle).
REQ-026 SHALL run a free-running BRIGHT_BITS PWM counter; enable of the current digit active only when pwm_count <= shadow brightness (all-ones = full on, excluding blanking).
REQ-027 SHALL keep the enable inactive for digits with shadow digit_enable bit 0; segments still driven.
REQ-028 SHALL decode nibbles to standard hex glyphs (internal active-high): 0=0111111, 1=0000110, 2=1011011, 8=1111111, A=1110111, F=1110001 (g..a); dp = shadow decimal point bit.
REQ-029 SHALL pulse frame_start for one cycle when the output stage enters index 0, prescaler 0.

Reset
REQ-030 SHALL on reset clear prescaler, index, PWM counter, blink counter and all shadows to 0.
REQ-031 SHALL on reset drive all segments off, all enables inactive (per polarity parameters), update_ack = 0, frame_start = 0; reset SHALL override a coincident capture.

Configuration
REQ-032 SHALL, with LED_DISPLAY_BLINK_EN defined, toggle a blink phase every BLINK_HALF cycles and force enables inactive for shadow blink_mask digits while phase = 1; phase = 0 after reset.
REQ-033 SHALL, without LED_DISPLAY_BLINK_EN, keep port blink_mask but ignore it and implement no blink counter.

Verification (NUM_DIGITS=4, CLK_RATE_HZ=10000, DIGIT_RATE_HZ=2500 so DWELL=4, BRIGHT_BITS=2, active-high polarities)
REQ-034 SHALL cover: reset released, no update -> enables stay 0000 indefinitely; frame_start every 16 cycles.
REQ-035 SHALL cover: data=16'h8A21, enable=1111, dp=0101, brightness=3, update held -> one update_ack; next frame digit0 segments 1_0000110, digit3 0_1111111, enables 0001,0010,0100,1000 each on 3 of 4 cycles.
REQ-036 SHALL cover: brightness=0 -> per digit enable active only when PWM count = 0.
REQ-037 SHALL cover: update pulsed 2 cycles mid-frame -> no update_ack, shadows unchanged.
REQ-038 SHALL cover: reset asserted in capture cycle -> no update_ack, outputs inactive next cycle.
REQ-039 SHALL cover, with LED_DISPLAY_BLINK_EN, BLINK_HZ=1000: blink_mask=0010 -> digit1 enable absent during alternate 5-cycle windows, other digits unaffected.
